matrix_operand_loader: RTL and testbench
========================================

# matrix_operand_loader

Upstream feeder for the 3x3 matrix scalar-division datapath. It accepts operand values serially as 4-bit binary words over a valid/ready handshake and decodes each word into a 16-bit one-hot code. It assembles a complete frame, 9 divisor elements followed by 9 dividend elements, and holds it on two flat one-hot buses. The frame is released to the division stage with a frame-level valid/ready handshake.

## Interface
Parameters:
- N_ELEM, 9, elements per matrix (row-major, element 0 = top-left)
- VAL_W, 4, binary width of one element; one-hot code width CODE_W = 2**VAL_W

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream word valid
- in_ready  out  1  loader can accept a word this cycle
- in_data  in  VAL_W  operand value, binary
- flush  in  1  synchronous abort of the frame being built or held
- div_code  out  N_ELEM*CODE_W  divisor matrix one-hot codes; element k at bits [k*CODE_W+CODE_W-1 : k*CODE_W]
- dvd_code  out  N_ELEM*CODE_W  dividend matrix one-hot codes, same packing
- frame_valid  out  1  both code buses hold a complete frame
- frame_ready  in  1  division stage consumes the frame
- div_zero  out  N_ELEM  per-element flag, divisor element equals 0 (see Configuration)

## Operation
- Word accepted when in_valid && in_ready.
- Word index w counts 0..2*N_ELEM-1:
  - w < N_ELEM: writes div_code element w.
  - otherwise: writes dvd_code element w-N_ELEM.
- Decode: value v sets bit v of the element slice. All other bits of that slice are 0, so exactly one bit is set per written element.
- States:
  - LOAD: in_ready=1, frame_valid=0. On each accept, w increments. On the accept with w=2*N_ELEM-1, go to FULL.
  - FULL: in_ready=0, frame_valid=1. Buses are stable. When frame_ready=1, go to LOAD with w=0.
- Buses are not cleared between frames. Every element is overwritten before the next FULL.
- flush=1 in any state: next cycle is LOAD with w=0, and both buses are cleared to all-zero.
  - flush beats a simultaneous accept: the word is dropped.
  - flush beats a simultaneous frame_ready: no effect beyond the return to LOAD.
- in_data is ignored when in_valid=0 or in_ready=0.
- Reset values:
  - State LOAD, w=0.
  - in_ready=1, frame_valid=0.
  - div_code, dvd_code and div_zero all 0.

## Timing
- in_ready is a combinational decode of the state register. frame_valid, the code buses and div_zero are registered.
- A word accepted in cycle n appears on its bus slice in cycle n+1.
- frame_valid rises the cycle after the final (18th) accept.
- Handshake in FULL: frame_ready sampled high in cycle n drops frame_valid and raises in_ready in cycle n+1.
  - There is one bubble between frames: the first word of the next frame is accepted no earlier than n+1.
- Minimum frame period is 2*N_ELEM+1 cycles with continuous in_valid and frame_ready tied high.
- Reset mid-frame discards partial data, identical to flush plus a return to reset values.

## Configuration
- ZERO_DIV_CHECK_EN defined:
  - div_zero[k] is registered, set when divisor element k is written with value 0, and cleared when it is written with a nonzero value.
  - div_zero is cleared by flush and by reset.
  - Valid whenever frame_valid=1.
- ZERO_DIV_CHECK_EN undefined: div_zero is tied to 0 and no compare logic is built.

## Structure
- Shared package matrix_pkg holds:
  - VAL_W, CODE_W and N_ELEM defaults
  - the state enum {LOAD, FULL}
  - the word-index width localparam ($clog2(2*N_ELEM))
- Sub-module onehot_decode4: combinational VAL_W to CODE_W one-hot decoder. A single instance sits on in_data, and its output is written into the addressed slice.

## Test plan
- Reset, then stream values 0..8 as divisors and 15..7 descending as dividends with frame_ready=0:
  - frame_valid rises one cycle after the 18th accept.
  - div_code element 3 = 16'h0008; dvd_code element 0 = 16'h8000.
  - in_ready=0 while in FULL.
- Hold FULL for 5 cycles, then pulse frame_ready: frame_valid falls next cycle, in_ready=1, and the next word lands in div_code element 0.
- Assert flush after 11 accepts, together with an in_valid word:
  - That word is dropped and both buses read 0.
  - A fresh 18-word stream completes normally.
- Toggle in_valid randomly with constant in_data=4'hA: every element equals 16'h0400 and exactly 18 accepts occur before FULL.
- With ZERO_DIV_CHECK_EN defined, set divisor elements 2 and 7 to 0 and the rest to 1: div_zero = 9'b010000100. A following frame with all 1s clears it to 0.
- Assert rst during FULL: next cycle frame_valid=0, in_ready=1, buses 0, div_zero 0.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants and state type for the matrix operand loader.
package matrix_pkg;

  localparam int unsigned N_ELEM = 9;
  localparam int unsigned VAL_W  = 4;
  localparam int unsigned CODE_W = 2 ** VAL_W;
  localparam int unsigned IDX_W  = $clog2(2 * N_ELEM);

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } state_e;

endpackage

// File: rtl/matrix_operand_loader_if.sv
// Word-in / frame-out handshake bundle of the matrix operand loader.
interface matrix_operand_loader_if #(
  parameter int unsigned N_ELEM = matrix_pkg::N_ELEM,
  parameter int unsigned VAL_W  = matrix_pkg::VAL_W
);

  localparam int unsigned CODE_W = 2 ** VAL_W;

  logic                       in_valid;
  logic                       in_ready;
  logic [VAL_W-1:0]           in_data;
  logic                       flush;
  logic [N_ELEM*CODE_W-1:0]   div_code;
  logic [N_ELEM*CODE_W-1:0]   dvd_code;
  logic                       frame_valid;
  logic                       frame_ready;
  logic [N_ELEM-1:0]          div_zero;

  // Upstream word source and downstream frame consumer.
  modport master (
    output in_valid, in_data, flush, frame_ready,
    input  in_ready, div_code, dvd_code, frame_valid, div_zero
  );

  // The loader itself.
  modport slave (
    input  in_valid, in_data, flush, frame_ready,
    output in_ready, div_code, dvd_code, frame_valid, div_zero
  );

endinterface

// File: rtl/onehot_decode4.sv
// Combinational binary to one-hot decoder (VAL_W in, 2**VAL_W out).
module onehot_decode4 #(
  parameter int unsigned VAL_W  = 4,
  parameter int unsigned CODE_W = 2 ** VAL_W
) (
  input  logic [VAL_W-1:0]  val_i,
  output logic [CODE_W-1:0] code_o
);

  always_comb begin
    code_o         = '0;
    code_o[val_i]  = 1'b1;
  end

endmodule

// File: rtl/matrix_operand_loader.sv
// Serial operand loader: 9 divisor then 9 dividend words, one-hot decoded into a held frame.
// Optional per-element divisor-zero flags built when ZERO_DIV_CHECK_EN is defined.
module matrix_operand_loader #(
  parameter int unsigned N_ELEM = matrix_pkg::N_ELEM,
  parameter int unsigned VAL_W  = matrix_pkg::VAL_W
) (
  input  logic                     clk,
  input  logic                     rst,
  matrix_operand_loader_if.slave   bus
);

  import matrix_pkg::*;

  localparam int unsigned CodeW = 2 ** VAL_W;
  localparam int unsigned IdxW  = $clog2(2 * N_ELEM);
  localparam int unsigned BusW  = N_ELEM * CodeW;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(2 * N_ELEM - 1);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   w_q, w_d;
  logic [BusW-1:0]   div_q, div_d;
  logic [BusW-1:0]   dvd_q, dvd_d;
  logic [CodeW-1:0]  code;
  logic              accept;

  onehot_decode4 #(
    .VAL_W  (VAL_W),
    .CODE_W (CodeW)
  ) u_decode (
    .val_i  (bus.in_data),
    .code_o (code)
  );

`ifdef ZERO_DIV_CHECK_EN
  logic [N_ELEM-1:0] zero_q, zero_d;
`endif

  assign accept = bus.in_valid && (state_q == LOAD);

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    div_d   = div_q;
    dvd_d   = dvd_q;
`ifdef ZERO_DIV_CHECK_EN
    zero_d  = zero_q;
`endif
    // flush wins over any accept or frame_ready in the same cycle
    if (bus.flush) begin
      state_d = LOAD;
      w_d     = '0;
      div_d   = '0;
      dvd_d   = '0;
`ifdef ZERO_DIV_CHECK_EN
      zero_d  = '0;
`endif
    end else begin
      case (state_q)
        LOAD: begin
          if (accept) begin
            for (int k = 0; k < N_ELEM; k++) begin
              if (w_q == IdxW'(k)) begin
                div_d[k*CodeW +: CodeW] = code;
`ifdef ZERO_DIV_CHECK_EN
                zero_d[k] = (bus.in_data == '0);
`endif
              end
              if (w_q == IdxW'(k + N_ELEM)) begin
                dvd_d[k*CodeW +: CodeW] = code;
              end
            end
            if (w_q == LastIdx) begin
              state_d = FULL;
              w_d     = '0;
            end else begin
              w_d = w_q + IdxW'(1);
            end
          end
        end
        FULL: begin
          if (bus.frame_ready) begin
            state_d = LOAD;
            w_d     = '0;
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      w_q     <= '0;
      div_q   <= '0;
      dvd_q   <= '0;
`ifdef ZERO_DIV_CHECK_EN
      zero_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      div_q   <= div_d;
      dvd_q   <= dvd_d;
`ifdef ZERO_DIV_CHECK_EN
      zero_q  <= zero_d;
`endif
    end
  end

  assign bus.in_ready    = (state_q == LOAD);
  assign bus.frame_valid = (state_q == FULL);
  assign bus.div_code    = div_q;
  assign bus.dvd_code    = dvd_q;
`ifdef ZERO_DIV_CHECK_EN
  assign bus.div_zero    = zero_q;
`else
  assign bus.div_zero    = '0;
`endif

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed self-checking bench for matrix_operand_loader.
module tb_matrix_operand_loader;

  import matrix_pkg::*;

  localparam int unsigned BW = N_ELEM * CODE_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_operand_loader_if bus ();

  matrix_operand_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int wc     = 0;
  logic [BW-1:0] exp_div = '0;
  logic [BW-1:0] exp_dvd = '0;

  task automatic check_val(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CODE_W-1:0] onehot(input logic [VAL_W-1:0] v);
    logic [CODE_W-1:0] one;
    one = 1;
    return one << v;
  endfunction

  task automatic model_accept(input logic [VAL_W-1:0] v);
    if (wc < N_ELEM) exp_div[wc*CODE_W +: CODE_W] = onehot(v);
    else             exp_dvd[(wc-N_ELEM)*CODE_W +: CODE_W] = onehot(v);
    wc = (wc == 2*N_ELEM-1) ? 0 : wc + 1;
  endtask

  task automatic model_clear();
    exp_div = '0;
    exp_dvd = '0;
    wc      = 0;
  endtask

  // Called at #1 after an edge; returns at #1 after the accepting edge.
  task automatic send(input logic [VAL_W-1:0] v);
    int n;
    n            = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      check_val("send_timeout", BW'(n), '0);
    end else begin
      @(posedge clk); #1;
      model_accept(v);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic release_frame();
    bus.frame_ready = 1'b1;
    @(posedge clk); #1;
    bus.frame_ready = 1'b0;
  endtask

  initial begin
    logic [VAL_W-1:0] v;
    int cyc;
    int acc_cnt;
    logic acc;

    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.flush       = 1'b0;
    bus.frame_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_in_ready", BW'(bus.in_ready), BW'(1));
    check_val("rst_frame_valid", BW'(bus.frame_valid), '0);
    check_val("rst_div_code", bus.div_code, '0);
    check_val("rst_dvd_code", bus.dvd_code, '0);
    check_val("rst_div_zero", BW'(bus.div_zero), '0);
    rst = 1'b0;

    // Frame 1: divisors 0..8, dividends 15..7
    for (int i = 0; i < 2*N_ELEM; i++) begin
      v = (i < N_ELEM) ? VAL_W'(i) : VAL_W'(15 - (i - N_ELEM));
      send(v);
      if (i == 2*N_ELEM-2) check_val("fv_before_last", BW'(bus.frame_valid), '0);
    end
    check_val("fv_after_last", BW'(bus.frame_valid), BW'(1));
    check_val("full_in_ready", BW'(bus.in_ready), '0);
    check_val("div_elem3", BW'(bus.div_code[3*CODE_W +: CODE_W]), BW'(16'h0008));
    check_val("dvd_elem0", BW'(bus.dvd_code[0 +: CODE_W]), BW'(16'h8000));
    check_val("f1_div", bus.div_code, exp_div);
    check_val("f1_dvd", bus.dvd_code, exp_dvd);

    // Hold FULL 5 cycles with a word offered; it must be ignored
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h9;
    repeat (5) begin @(posedge clk); #1; end
    bus.in_valid = 1'b0;
    check_val("hold_fv", BW'(bus.frame_valid), BW'(1));
    check_val("hold_div", bus.div_code, exp_div);
    check_val("hold_dvd", bus.dvd_code, exp_dvd);

    release_frame();
    check_val("rel_fv", BW'(bus.frame_valid), '0);
    check_val("rel_in_ready", BW'(bus.in_ready), BW'(1));
    send(4'h5);
    check_val("next_div_elem0", BW'(bus.div_code[0 +: CODE_W]), BW'(16'h0020));
    check_val("next_div_elem1_kept", BW'(bus.div_code[CODE_W +: CODE_W]), BW'(16'h0002));

    // 10 more accepts (11 total), then flush with a word offered
    for (int i = 0; i < 10; i++) send(VAL_W'((i * 3) % 16));
    check_val("pre_flush_dvd", bus.dvd_code, exp_dvd);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h3;
    bus.flush    = 1'b1;
    @(posedge clk); #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    model_clear();
    check_val("flush_div", bus.div_code, '0);
    check_val("flush_dvd", bus.dvd_code, '0);
    check_val("flush_in_ready", BW'(bus.in_ready), BW'(1));
    check_val("flush_fv", BW'(bus.frame_valid), '0);

    for (int i = 0; i < 2*N_ELEM; i++) send(VAL_W'((i * 7 + 3) % 16));
    check_val("f2_fv", BW'(bus.frame_valid), BW'(1));
    check_val("f2_div", bus.div_code, exp_div);
    check_val("f2_dvd", bus.dvd_code, exp_dvd);
    check_val("f2_div_elem0", BW'(bus.div_code[0 +: CODE_W]), BW'(16'h0008));
    release_frame();
    check_val("f2_rel_in_ready", BW'(bus.in_ready), BW'(1));

    // Random in_valid, constant 4'hA
    cyc     = 0;
    acc_cnt = 0;
    bus.in_data = 4'hA;
    while (!bus.frame_valid && cyc < 500) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (acc) begin
        model_accept(4'hA);
        acc_cnt++;
      end
      cyc++;
    end
    bus.in_valid = 1'b0;
    check_val("rand_timeout", BW'(cyc < 500), BW'(1));
    check_val("rand_accepts", BW'(acc_cnt), BW'(18));
    check_val("rand_div", bus.div_code, {N_ELEM{16'h0400}});
    check_val("rand_dvd", bus.dvd_code, {N_ELEM{16'h0400}});
    release_frame();

    // Divisor-zero flags
    for (int i = 0; i < 2*N_ELEM; i++) send((i == 2 || i == 7) ? 4'h0 : 4'h1);
`ifdef ZERO_DIV_CHECK_EN
    check_val("zero_set", BW'(bus.div_zero), BW'(9'b010000100));
`else
    check_val("zero_set", BW'(bus.div_zero), '0);
`endif
    check_val("zero_div", bus.div_code, exp_div);
    release_frame();
    for (int i = 0; i < 2*N_ELEM; i++) send(4'h1);
    check_val("zero_clear", BW'(bus.div_zero), '0);
    check_val("zero_fv", BW'(bus.frame_valid), BW'(1));

    // Reset while FULL
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    check_val("rst_full_fv", BW'(bus.frame_valid), '0);
    check_val("rst_full_in_ready", BW'(bus.in_ready), BW'(1));
    check_val("rst_full_div", bus.div_code, '0);
    check_val("rst_full_dvd", bus.dvd_code, '0);
    check_val("rst_full_zero", BW'(bus.div_zero), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
